muladd_acc_pipe: RTL and testbench
==================================

MULADD_ACC_PIPE -- requirements
Module: muladd_acc_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width per lane.
REQ-002 SHALL have parameter LANES, default 4, number of multiply lanes, 1..16.
REQ-003 SHALL have parameter ACC_W, default 48, internal accumulator width, >= RESULT_W and >= 2*DATA_W+clog2(LANES).
REQ-004 SHALL have parameter RESULT_W, default 32, output result width.
REQ-005 SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 SHALL have ports as follows:
 clk  input  1  clock, rising edge
 rst_n  input  1  asynchronous active-low reset
 in_valid  input  1  beat present
 in_ready  output  1  beat can be accepted
 in_last  input  1  final beat of a vector
 signed_mode  input  1  1 = two's-complement operands for this beat
 dataa  input  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
 datab  input  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
 out_valid  output  1  result present
 out_ready  input  1  sink accepts result
 result  output  RESULT_W  dot-product result
 out_ovf  output  1  result not representable in RESULT_W

Function
REQ-007 SHALL accept a beat when in_valid && in_ready at a rising clk edge.
REQ-008 SHALL compute per beat the sum over lanes of dataa[i]*datab[i], sign-extending when signed_mode=1 and zero-extending otherwise.
REQ-009 SHALL pipeline as S1 (per-lane product registers), S2 (lane-sum register), S3 (accumulator and result register), each carrying valid, last and signed_mode tags.
REQ-010 SHALL use one advance enable adv = !(out_valid && !out_ready); in_ready = adv; all stages freeze when adv=0.
REQ-011 SHALL add each S2 sum into the ACC_W accumulator, starting from zero on the first beat of a vector; ACC_W overflow wraps silently.
REQ-012 SHALL, when an S2 beat with last=1 advances, load result/out_ovf from the final accumulator, set out_valid, and restart accumulation for the next beat.
REQ-013 SHALL assert out_valid exactly 3 clk cycles after acceptance of the in_last beat when no stall occurs.
REQ-014 SHALL allow bubbles (in_valid=0) inside a vector without affecting the accumulation.
REQ-015 SHALL hold result and out_ovf stable while out_valid && !out_ready.
REQ-016 SHALL, on out_valid && out_ready in the same cycle a new result completes, load the new result and keep out_valid=1; otherwise clear out_valid on handshake.
REQ-017 SHALL set out_ovf when the final accumulator is outside the RESULT_W range, signed range if the last beat's signed_mode=1, else unsigned range.
REQ-018 SHALL treat a vector whose first beat has in_last=1 as a single-beat dot product.

Reset
REQ-019 SHALL, while rst_n=0, clear all stage valids, accumulator, result, out_ovf and out_valid to 0 asynchronously.
REQ-020 SHALL discard any partial vector on reset; the first beat after release starts a new vector.

Configuration
REQ-021 SHALL, with MULADD_ACC_SAT_EN defined, clamp result to the RESULT_W max/min (signed or unsigned per REQ-017) when out_ovf=1.
REQ-022 SHALL, without MULADD_ACC_SAT_EN, output the low RESULT_W bits of the accumulator (wrap); out_ovf is reported in both builds.

Verification (defaults: DATA_W=16, LANES=4, RESULT_W=32)
REQ-023 SHALL cover: unsigned a={1,2,3,4}, b={1,1,1,1}, last -> result=10, out_ovf=0, out_valid 3 cycles after acceptance.
REQ-024 SHALL cover: two beats a={1,2,3,4}/b=1s then a=5s/b=2s last, with a bubble between them -> result=50.
REQ-025 SHALL cover: a lane0=0xFFFD, b lane0=7, other lanes 0; signed -> 0xFFFFFFEB; unsigned -> 0x0006FFEB.
REQ-026 SHALL cover: out_ready=0 with two vectors sent -> in_ready=0, first result held stable; raising out_ready delivers both in order.
REQ-027 SHALL cover: unsigned, all operands 0xFFFF, 2 beats -> out_ovf=1; result=0xFFF00008 without MULADD_ACC_SAT_EN, 0xFFFFFFFF with it.
REQ-028 SHALL cover: rst_n pulsed low after the first beat of a vector, then one beat a=1s, b=1s, last -> result=4.

Source files
------------

// File: rtl/muladd_acc_pipe.sv
// muladd_acc_pipe: multi-lane multiply-add dot-product engine with a vector
// accumulator.
//
// Each accepted beat carries LANES operand pairs. The beat's lane products
// are summed and added into an accumulator. The beat flagged in_last closes
// the vector and produces one result.
//
// Pipeline:
//   S1  per-lane product registers
//   S2  lane-sum register
//   S3  accumulator and result register
//
// Configuration:
//   MULADD_ACC_SAT_EN  When defined, an out-of-range result is clamped to the
//                      RESULT_W max/min. When undefined, the low RESULT_W
//                      accumulator bits are output (wrap). out_ovf is
//                      reported in both builds.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     input beat present
//   in_ready     input beat can be accepted
//   in_last      final beat of a vector
//   signed_mode  1 = two's-complement operands for this beat
//   dataa        lane i operand A at [i*DATA_W +: DATA_W]
//   datab        lane i operand B at [i*DATA_W +: DATA_W]
//   out_valid    result present
//   out_ready    sink accepts result
//   result       dot-product result (RESULT_W bits)
//   out_ovf      accumulator value not representable in RESULT_W
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid never waits on ready. Once out_valid is raised, result
// and out_ovf stay frozen until out_ready takes them. A single advance
// enable (adv) freezes every stage while the output is blocked, so
// in_ready is simply adv.
module muladd_acc_pipe #(
  parameter int DATA_W   = 16,
  parameter int LANES    = 4,
  parameter int ACC_W    = 48,
  parameter int RESULT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic                      signed_mode,
  input  logic [LANES*DATA_W-1:0]   dataa,
  input  logic [LANES*DATA_W-1:0]   datab,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RESULT_W-1:0]       result,
  output logic                      out_ovf
);

  logic adv;
  logic accept;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // S1: per-lane products
  // Each operand is widened by one bit: sign bit in signed mode, zero
  // otherwise. The product is then formed as a signed multiply at ACC_W
  // width. All later arithmetic is modulo 2^ACC_W, so the lane sums and the
  // accumulator need no further sign handling.
  logic [DATA_W:0]                ext_a;
  logic [DATA_W:0]                ext_b;
  logic [LANES-1:0][ACC_W-1:0]    prod_c;
  logic [LANES-1:0][ACC_W-1:0]    s1_prod;
  logic                           s1_valid;
  logic                           s1_last;
  logic                           s1_sgn;

  always_comb begin
    ext_a  = '0;
    ext_b  = '0;
    prod_c = '0;
    for (int i = 0; i < LANES; i++) begin
      ext_a = {signed_mode & dataa[i*DATA_W + DATA_W - 1], dataa[i*DATA_W +: DATA_W]};
      ext_b = {signed_mode & datab[i*DATA_W + DATA_W - 1], datab[i*DATA_W +: DATA_W]};
      prod_c[i] = ACC_W'($signed(ext_a) * $signed(ext_b));
    end
  end

  // S2: lane sum
  logic [ACC_W-1:0] sum_c;
  logic [ACC_W-1:0] s2_sum;
  logic             s2_valid;
  logic             s2_last;
  logic             s2_sgn;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + s1_prod[i];
    end
  end

  // S3: accumulate, range check, result
  // The accumulator always holds the running sum of the open vector. It is
  // zeroed when a vector closes, so the next beat naturally starts from zero.
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    total;
  logic [ACC_W-1:0]    hi_bits;
  logic                ovf_c;
  logic [RESULT_W-1:0] res_c;

  assign total = acc + s2_sum;

  // Signed range holds when every bit from RESULT_W-1 upward matches the
  // sign. Unsigned range holds when nothing is set at or above RESULT_W.
  always_comb begin
    hi_bits = '0;
    ovf_c   = 1'b0;
    if (s2_sgn) begin
      hi_bits = ACC_W'($signed(total) >>> (RESULT_W - 1));
      ovf_c   = !((hi_bits == '0) || (hi_bits == '1));
    end else begin
      hi_bits = total >> RESULT_W;
      ovf_c   = (hi_bits != '0);
    end
  end

`ifdef MULADD_ACC_SAT_EN
  always_comb begin
    res_c = total[RESULT_W-1:0];
    if (ovf_c) begin
      if (s2_sgn) begin
        res_c = total[ACC_W-1] ? {1'b1, {(RESULT_W-1){1'b0}}}
                               : {1'b0, {(RESULT_W-1){1'b1}}};
      end else begin
        res_c = '1;
      end
    end
  end
`else
  assign res_c = total[RESULT_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sgn    <= 1'b0;
      s1_prod   <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_sgn    <= 1'b0;
      s2_sum    <= '0;
      acc       <= '0;
      result    <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_last <= in_last;
        s1_sgn  <= signed_mode;
        s1_prod <= prod_c;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_sgn  <= s1_sgn;
        s2_sum  <= sum_c;
      end

      if (s2_valid) begin
        if (s2_last) begin
          acc     <= '0;
          result  <= res_c;
          out_ovf <= ovf_c;
        end else begin
          acc <= total;
        end
      end

      // With adv high, a set out_valid implies out_ready, so the old result
      // is consumed this edge. out_valid therefore only survives if a new
      // result lands at the same time.
      out_valid <= s2_valid && s2_last;
    end
  end

endmodule

// File: tb/tb_muladd_acc_pipe.sv
// tb_muladd_acc_pipe: self-checking bench for muladd_acc_pipe at its
// default parameters (DATA_W=16, LANES=4, ACC_W=48, RESULT_W=32).
//
// Expected {out_ovf, result} pairs are queued as the closing beat of each
// vector is driven. They are popped and compared when the DUT hands a
// result over.
module tb_muladd_acc_pipe;

  localparam int DW = 16;
  localparam int L  = 4;
  localparam int AW = 48;
  localparam int RW = 32;

`ifdef MULADD_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic          signed_mode;
  logic [L*DW-1:0] dataa;
  logic [L*DW-1:0] datab;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          out_ovf;

  muladd_acc_pipe #(
    .DATA_W(DW), .LANES(L), .ACC_W(AW), .RESULT_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .signed_mode(signed_mode), .dataa(dataa), .datab(datab),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_ovf(out_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [RW:0] exp_q[$];   // {ovf, result}
  logic [RW:0] mon_e;
  bit          rand_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW:0] expect_val(input logic [31:0] wrap, input logic [31:0] sat,
                                             input logic ovf);
    return {ovf, (SAT && ovf) ? sat : wrap};
  endfunction

  // scoreboard: compare on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h with no expected value queued", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {32'b0, result}, {32'b0, mon_e[RW-1:0]});
        check("out_ovf", {63'b0, out_ovf}, {63'b0, mon_e[RW]});
      end
    end
  end

  // random back-pressure, changed away from both sampling points
  always @(posedge clk) begin
    if (rand_on) begin
      #2 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic drive_beat(input logic [63:0] a, input logic [63:0] b,
                            input logic sgn, input logic last);
    bit ok;
    bit done;
    int n;
    dataa       = a;
    datab       = b;
    signed_mode = sgn;
    in_last     = last;
    in_valid    = 1'b1;
    done        = 1'b0;
    n           = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      done = ok;
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic longint dot(input logic [63:0] a, input logic [63:0] b, input logic sgn);
    longint s;
    longint x;
    longint y;
    logic [15:0] ta;
    logic [15:0] tb;
    s = 0;
    for (int i = 0; i < L; i++) begin
      ta = a[i*16 +: 16];
      tb = b[i*16 +: 16];
      x = sgn ? longint'($signed(ta)) : longint'({48'b0, ta});
      y = sgn ? longint'($signed(tb)) : longint'({48'b0, tb});
      s = s + x * y;
    end
    return s;
  endfunction

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sgn;
    logic        last;
    int          gap;
    logic [RW:0] exp;
  } beat_t;

  beat_t tbl[$];

  localparam logic [63:0] ONES = 64'h0001_0001_0001_0001;
  localparam logic [63:0] FS   = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    longint      v;
    logic        ovf;
    logic [31:0] sat;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rs;
    int          nb;
    logic [31:0] held;

    // stimulus table: {a, b, signed, last, idle cycles after, expected}
    tbl.push_back('{64'h0004_0003_0002_0001, ONES, 1'b0, 1'b1, 0,
                    expect_val(32'd10, 32'd10, 1'b0)});
    tbl.push_back('{64'h0004_0003_0002_0001, ONES, 1'b0, 1'b0, 2, '0});
    tbl.push_back('{64'h0005_0005_0005_0005, 64'h0002_0002_0002_0002, 1'b0, 1'b1, 0,
                    expect_val(32'd50, 32'd50, 1'b0)});
    tbl.push_back('{64'h0000_0000_0000_FFFD, 64'h7, 1'b1, 1'b1, 0,
                    expect_val(32'hFFFF_FFEB, 32'hFFFF_FFEB, 1'b0)});
    tbl.push_back('{64'h0000_0000_0000_FFFD, 64'h7, 1'b0, 1'b1, 1,
                    expect_val(32'h0006_FFEB, 32'h0006_FFEB, 1'b0)});
    tbl.push_back('{FS, FS, 1'b0, 1'b0, 0, '0});
    tbl.push_back('{FS, FS, 1'b0, 1'b1, 0,
                    expect_val(32'hFFF0_0008, 32'hFFFF_FFFF, 1'b1)});
    tbl.push_back('{64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b1, 1'b1, 0,
                    expect_val(32'h0000_0000, 32'h7FFF_FFFF, 1'b1)});
    tbl.push_back('{64'h8000_8000_8000_8000, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1, 1'b1, 0,
                    expect_val(32'h0002_0000, 32'h8000_0000, 1'b1)});
    tbl.push_back('{64'h0000_FFFF_FFFF_FFFF, 64'h0000_0001_0001_FFFF, 1'b0, 1'b1, 0,
                    expect_val(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0)});
    tbl.push_back('{64'h0001_FFFF_FFFF_FFFF, 64'h0001_0001_0001_FFFF, 1'b0, 1'b1, 0,
                    expect_val(32'h0000_0000, 32'hFFFF_FFFF, 1'b1)});
    tbl.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 1'b1, 0,
                    expect_val(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0)});

    // reset state
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
    dataa = '0; datab = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_result", {32'b0, result}, 64'd0);
    check("reset_out_ovf", {63'b0, out_ovf}, 64'd0);
    rst_n = 1'b1;
    idle(1);

    // latency: out_valid rises on the third edge counting the accepting one
    exp_q.push_back(expect_val(32'd10, 32'd10, 1'b0));
    drive_beat(64'h0004_0003_0002_0001, ONES, 1'b0, 1'b1);
    check("lat_edge1", {63'b0, out_valid}, 64'd0);
    idle(1);
    check("lat_edge2", {63'b0, out_valid}, 64'd0);
    idle(1);
    check("lat_edge3", {63'b0, out_valid}, 64'd1);
    drain();

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].last) exp_q.push_back(tbl[i].exp);
      drive_beat(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].last);
      if (tbl[i].gap > 0) idle(tbl[i].gap);
    end
    drain();

    // stall: two vectors against a blocked sink
    out_ready = 1'b0;
    exp_q.push_back(expect_val(32'd10, 32'd10, 1'b0));
    drive_beat(64'h0004_0003_0002_0001, ONES, 1'b0, 1'b1);
    exp_q.push_back(expect_val(32'd40, 32'd40, 1'b0));
    drive_beat(64'h0005_0005_0005_0005, 64'h0002_0002_0002_0002, 1'b0, 1'b1);
    idle(4);
    check("stall_out_valid", {63'b0, out_valid}, 64'd1);
    check("stall_in_ready", {63'b0, in_ready}, 64'd0);
    check("stall_result", {32'b0, result}, 64'd10);
    held = result;
    idle(3);
    check("stall_hold", {32'b0, result}, {32'b0, held});
    check("stall_hold_valid", {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1;
    drain();

    // reset in the middle of a vector discards the partial sum
    drive_beat(FS, FS, 1'b0, 1'b0);
    idle(2);
    rst_n = 1'b0;
    #2;
    check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    check("midreset_result", {32'b0, result}, 64'd0);
    check("midreset_in_ready", {63'b0, in_ready}, 64'd1);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back(expect_val(32'd4, 32'd4, 1'b0));
    drive_beat(ONES, ONES, 1'b0, 1'b1);
    drain();

    // random vectors under random back-pressure
    rand_on = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rs = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      v  = 0;
      for (int j = 0; j < nb; j++) begin
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        v  = v + dot(ra, rb, rs);
        if (j == nb - 1) begin
          if (rs) begin
            ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648);
            sat = (v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end else begin
            ovf = (v > 64'sd4294967295);
            sat = 32'hFFFF_FFFF;
          end
          exp_q.push_back(expect_val(v[31:0], sat, ovf));
        end
        drive_beat(ra, rb, rs, (j == nb - 1));
        idle($urandom_range(0, 2));
      end
    end
    rand_on = 1'b0;
    @(posedge clk);
    #3 out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
